// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback stage: wb value select, 32-entry regfile with bypass, fwd bus, instret
// x0 is never written; reads of x0 are forced to zero rather than relying on the array.
module wb_regfile #(
  parameter int DWIDTH = 32,
  parameter int NREGS  = 32,
  parameter int PC_INC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_stall,
  input  logic              wb_valid,
  input  logic [DWIDTH-1:0] wb_pc,
  input  logic [DWIDTH-1:0] wb_alu_result,
  input  logic [DWIDTH-1:0] wb_mem_data,
  input  logic [4:0]        wb_rd,
  input  logic              wb_regW,
  input  logic [1:0]        wb_WBSel,
  input  logic [4:0]        rs1_addr,
  input  logic [4:0]        rs2_addr,
  output logic [DWIDTH-1:0] rs1_data,
  output logic [DWIDTH-1:0] rs2_data,
  output logic              fwd_en,
  output logic [4:0]        fwd_rd,
  output logic [DWIDTH-1:0] fwd_data,
  output logic [63:0]       instret,
  output logic              wbsel_err
);

  logic [DWIDTH-1:0] regs_q [NREGS];
  logic [63:0]       instret_q, instret_d;
  logic              wbsel_err_q, wbsel_err_d;
  logic              retire, commit;
  logic [DWIDTH-1:0] wb_data;

  // Gating with rst_n keeps the bypass and forwarding paths quiet during reset.
  assign retire = rst_n & wb_valid & ~wb_stall;
  assign commit = retire & wb_regW & (wb_rd != 5'd0) & (wb_WBSel != 2'b11);

  always_comb begin
    wb_data = '0;
    case (wb_WBSel)
      2'b00:   wb_data = wb_alu_result;
      2'b01:   wb_data = wb_mem_data;
      2'b10:   wb_data = wb_pc + DWIDTH'(PC_INC);
      default: wb_data = '0;
    endcase
  end

  always_comb begin
    rs1_data = '0;
    if (rs1_addr == 5'd0)                rs1_data = '0;
    else if (commit && wb_rd == rs1_addr) rs1_data = wb_data;
    else                                 rs1_data = regs_q[rs1_addr];
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr == 5'd0)                rs2_data = '0;
    else if (commit && wb_rd == rs2_addr) rs2_data = wb_data;
    else                                 rs2_data = regs_q[rs2_addr];
  end

  always_comb begin
    instret_d   = instret_q + (retire ? 64'd1 : 64'd0);
    wbsel_err_d = wbsel_err_q | (retire & (wb_WBSel == 2'b11));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (commit) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q   <= '0;
      wbsel_err_q <= 1'b0;
    end else begin
      instret_q   <= instret_d;
      wbsel_err_q <= wbsel_err_d;
    end
  end

  assign fwd_en    = commit;
  assign fwd_rd    = wb_rd;
  assign fwd_data  = wb_data;
  assign instret   = instret_q;
  assign wbsel_err = wbsel_err_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed and randomized bench for wb_regfile against an array reference model
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst_n, wb_stall, wb_valid, wb_regW;
  logic [31:0] wb_pc, wb_alu_result, wb_mem_data;
  logic [4:0]  wb_rd, rs1_addr, rs2_addr, fwd_rd;
  logic [1:0]  wb_WBSel;
  logic [31:0] rs1_data, rs2_data, fwd_data;
  logic        fwd_en, wbsel_err;
  logic [63:0] instret;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] mreg [32];
  logic [63:0] m_instret;
  logic        m_err;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst_n(rst_n), .wb_stall(wb_stall), .wb_valid(wb_valid),
    .wb_pc(wb_pc), .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
    .wb_rd(wb_rd), .wb_regW(wb_regW), .wb_WBSel(wb_WBSel),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .instret(instret), .wbsel_err(wbsel_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    m_instret = 64'd0;
    m_err     = 1'b0;
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a, input logic cm,
                                           input logic [4:0] rd, input logic [31:0] wv);
    if (a == 5'd0)          return 32'd0;
    if (cm && rd == a)      return wv;
    return mreg[a];
  endfunction

  // Applies one MEM/WB entry, checks every output before the edge, then advances the model.
  task automatic step(input logic v, input logic st, input logic rw, input logic [1:0] sel,
                      input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] alu,
                      input logic [31:0] mem, input logic [4:0] a1, input logic [4:0] a2);
    logic [31:0] wv;
    logic        cm;
    wb_valid = v; wb_stall = st; wb_regW = rw; wb_WBSel = sel; wb_rd = rd;
    wb_pc = pc; wb_alu_result = alu; wb_mem_data = mem; rs1_addr = a1; rs2_addr = a2;
    #1;
    case (sel)
      2'd0:    wv = alu;
      2'd1:    wv = mem;
      2'd2:    wv = pc + 32'd4;
      default: wv = 32'd0;
    endcase
    cm = v && !st && rw && (rd != 5'd0) && (sel != 2'd3);
    chk("rs1_data", {32'd0, rs1_data}, {32'd0, exp_read(a1, cm, rd, wv)});
    chk("rs2_data", {32'd0, rs2_data}, {32'd0, exp_read(a2, cm, rd, wv)});
    chk("fwd_en", {63'd0, fwd_en}, {63'd0, cm});
    chk("fwd_rd", {59'd0, fwd_rd}, {59'd0, rd});
    chk("fwd_data", {32'd0, fwd_data}, {32'd0, wv});
    chk("instret", instret, m_instret);
    chk("wbsel_err", {63'd0, wbsel_err}, {63'd0, m_err});
    @(posedge clk);
    if (cm) mreg[rd] = wv;
    if (v && !st) begin
      m_instret = m_instret + 64'd1;
      if (sel == 2'd3) m_err = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle_read(input logic [4:0] a1, input logic [4:0] a2);
    wb_valid = 1'b0; wb_stall = 1'b0; rs1_addr = a1; rs2_addr = a2;
    #1;
  endtask

  task automatic random_phase(input int n);
    logic [1:0] sel;
    for (int i = 0; i < n; i++) begin
      sel = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      step($urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) != 0,
           sel, 5'($urandom), $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom));
    end
  endtask

  initial begin
    rst_n = 1'b0; wb_stall = 1'b0; wb_valid = 1'b0; wb_regW = 1'b0; wb_WBSel = 2'd0;
    wb_rd = 5'd0; wb_pc = '0; wb_alu_result = '0; wb_mem_data = '0;
    rs1_addr = 5'd3; rs2_addr = 5'd31;
    model_reset();
    @(negedge clk); #1;
    chk("reset_instret", instret, 64'd0);
    chk("reset_err", {63'd0, wbsel_err}, 64'd0);
    chk("reset_rs1", {32'd0, rs1_data}, 64'd0);
    chk("reset_rs2", {32'd0, rs2_data}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: ALU writeback with same-cycle bypass, then visible from the array
    step(1, 0, 1, 2'b00, 5'd5, 32'h0, 32'h0000_1234, 32'h0, 5'd5, 5'd5);
    idle_read(5'd5, 5'd0);
    chk("t1_rs1_next", {32'd0, rs1_data}, 64'h1234);
    chk("t1_instret", instret, 64'd1);

    // 2: rd=0 never writes, still retires
    step(1, 0, 1, 2'b00, 5'd0, 32'h0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd5);
    chk("t2_instret", instret, 64'd2);

    // 3: PC+4 source, including wrap
    step(1, 0, 1, 2'b10, 5'd1, 32'h0000_0100, 32'h0, 32'h0, 5'd1, 5'd2);
    idle_read(5'd1, 5'd0);
    chk("t3_pc4", {32'd0, rs1_data}, 64'h0000_0104);
    step(1, 0, 1, 2'b10, 5'd2, 32'hFFFF_FFFC, 32'h0, 32'h0, 5'd2, 5'd1);
    idle_read(5'd2, 5'd1);
    chk("t3_pc_wrap", {32'd0, rs1_data}, 64'd0);

    // 4: held under stall, commits and counts exactly once when released
    for (int i = 0; i < 3; i++)
      step(1, 1, 1, 2'b01, 5'd7, 32'h0, 32'h0, 32'hDEAD_BEEF, 5'd7, 5'd7);
    chk("t4_stall_instret", instret, 64'd4);
    step(1, 0, 1, 2'b01, 5'd7, 32'h0, 32'h0, 32'hDEAD_BEEF, 5'd7, 5'd7);
    idle_read(5'd7, 5'd7);
    chk("t4_x7", {32'd0, rs2_data}, 64'hDEAD_BEEF);
    chk("t4_instret", instret, 64'd5);

    // 5: illegal WBSel leaves x3 alone and sets the sticky flag
    step(1, 0, 1, 2'b11, 5'd3, 32'h0, 32'hAAAA_AAAA, 32'h0, 5'd3, 5'd3);
    step(0, 0, 0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 5'd3, 5'd3);
    chk("t5_err", {63'd0, wbsel_err}, 64'd1);
    chk("t5_instret", instret, 64'd6);

    random_phase(400);

    // 6: asynchronous reset mid-cycle, writes during reset ignored
    step(1, 0, 1, 2'b00, 5'd9, 32'h0, 32'h0000_0055, 32'h0, 5'd9, 5'd9);
    idle_read(5'd9, 5'd9);
    chk("t6_x9_pre", {32'd0, rs1_data}, 64'h55);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_rs1_rst", {32'd0, rs1_data}, 64'd0);
    chk("t6_instret_rst", instret, 64'd0);
    chk("t6_err_rst", {63'd0, wbsel_err}, 64'd0);
    wb_valid = 1'b1; wb_regW = 1'b1; wb_WBSel = 2'b00; wb_rd = 5'd9; wb_alu_result = 32'h77;
    #1;
    chk("t6_fwd_rst", {63'd0, fwd_en}, 64'd0);
    chk("t6_bypass_rst", {32'd0, rs1_data}, 64'd0);
    @(posedge clk); @(negedge clk);
    wb_valid = 1'b0;
    rst_n = 1'b1;
    idle_read(5'd9, 5'd9);
    chk("t6_x9_post", {32'd0, rs1_data}, 64'd0);
    chk("t6_instret_post", instret, 64'd0);

    random_phase(300);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
